// File: rtl/boot_rom_arb_pkg.sv
// Shared types and default sizing for the boot ROM arbiter.
// Holds the response tag carried from grant cycle to response cycle.
package boot_rom_arb_pkg;

    localparam int unsigned ROM_WORDS_DEF = 800;
    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned DATA_W_DEF    = 32;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } resp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, one-hot grant (bit0 = instr, bit1 = data).
// Grant is combinational from req; the last-grant pointer is registered.
module rr_arb2
    import boot_rom_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    owner_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == OWN_DATA) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = OWN_INSTR;
        end else if (gnt_o[1]) begin
            last_d = OWN_DATA;
        end
    end

    // Starts at DATA so the instruction port wins the first conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-port boot ROM between instruction and data ports, round-robin, one access per cycle.
// Optional BOOT_ROM_RANGE_CHECK_EN: out-of-range or misaligned accesses are granted but answered with err.
module boot_rom_arbiter
    import boot_rom_arb_pkg::*;
#(
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic [31:0]       data_addr_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,
    output logic              rom_csn_o,
    output logic [ADDR_W-1:0] rom_a_o,
    input  logic [DATA_W-1:0] rom_q_i
);

    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic [31:0]       win_addr;
    logic [ADDR_W-1:0] win_idx;
    logic              win_err;
    logic              access;
    logic [ADDR_W-1:0] a_q, a_d;
    resp_tag_t         resp_q, resp_d;

    rr_arb2 u_arb (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .req_i  ({data_req_i, instr_req_i}),
        .gnt_o  (arb_gnt)
    );

    // Grants are forced low while reset is asserted so every output shows its reset value.
    assign gnt      = arb_gnt & {2{RSTN}};
    assign win_addr = gnt[1] ? data_addr_i : instr_addr_i;
    assign win_idx  = win_addr[ADDR_W+1:2];

`ifdef BOOT_ROM_RANGE_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^win_addr[31:ADDR_W+2];
    assign win_err = ({{(32-ADDR_W){1'b0}}, win_idx} >= 32'(ROM_WORDS)) || (win_addr[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{win_addr[31:ADDR_W+2], win_addr[1:0]};
    assign win_err = 1'b0;
`endif

    assign access    = (|gnt) && !win_err;
    assign rom_csn_o = !access;
    assign rom_a_o   = access ? win_idx : a_q;

    always_comb begin
        a_d          = access ? win_idx : a_q;
        resp_d.valid = |gnt;
        resp_d.owner = gnt[1] ? OWN_DATA : OWN_INSTR;
        resp_d.err   = win_err;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_q    <= '0;
            resp_q <= '{valid: 1'b0, owner: OWN_INSTR, err: 1'b0};
        end else begin
            a_q    <= a_d;
            resp_q <= resp_d;
        end
    end

    assign instr_gnt_o    = gnt[0];
    assign data_gnt_o     = gnt[1];
    assign instr_rvalid_o = resp_q.valid && (resp_q.owner == OWN_INSTR);
    assign data_rvalid_o  = resp_q.valid && (resp_q.owner == OWN_DATA);
    assign instr_err_o    = instr_rvalid_o && resp_q.err;
    assign data_err_o     = data_rvalid_o && resp_q.err;
    assign instr_rdata_o  = (instr_rvalid_o && !resp_q.err) ? rom_q_i : '0;
    assign data_rdata_o   = (data_rvalid_o && !resp_q.err) ? rom_q_i : '0;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Bench for boot_rom_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a rule-level reference model.
module tb_boot_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        rom_csn_o;
    logic [9:0]  rom_a_o;
    logic [31:0] rom_q_i = '0;

    boot_rom_arbiter dut (
        .CLK(CLK), .RSTN(RSTN),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .rom_csn_o(rom_csn_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i)
    );

    always #5 CLK = ~CLK;

    // ROM macro model: data appears the cycle after chip select.
    logic [31:0] mem [0:1023];
    always @(posedge CLK) if (!rom_csn_o) rom_q_i <= mem[rom_a_o];

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_last_data;
    bit          p_vld, p_own_data, p_err;
    logic [31:0] p_dat;
    logic [9:0]  m_last_a;
    bit          g_i, g_d;

    task automatic model_reset();
        m_last_data = 1'b1;
        p_vld = 1'b0; p_own_data = 1'b0; p_err = 1'b0; p_dat = '0;
        m_last_a = '0;
        g_i = 1'b0; g_d = 1'b0;
    endtask

    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        bit          eg_i, eg_d, err, acc;
        logic [31:0] addr;
        logic [9:0]  idx;
        @(posedge CLK);
        #1;
        instr_req_i = ir; instr_addr_i = ia;
        data_req_i  = dr; data_addr_i  = da;
        @(negedge CLK);
        eg_i = ir && (!dr || m_last_data);
        eg_d = dr && (!ir || !m_last_data);
        addr = eg_d ? da : ia;
        idx  = addr[11:2];
        err  = 1'b0;
`ifdef BOOT_ROM_RANGE_CHECK_EN
        err  = (idx >= 10'd800) || (addr[1:0] != 2'b00);
`endif
        acc  = (eg_i || eg_d) && !err;
        check_val("instr_gnt", instr_gnt_o, eg_i);
        check_val("data_gnt", data_gnt_o, eg_d);
        check_val("gnt_onehot", instr_gnt_o & data_gnt_o, 0);
        check_val("rom_csn", rom_csn_o, !acc);
        check_val("rom_a", rom_a_o, acc ? idx : m_last_a);
        check_val("instr_rvalid", instr_rvalid_o, p_vld && !p_own_data);
        check_val("instr_rdata", instr_rdata_o, (p_vld && !p_own_data && !p_err) ? p_dat : 32'h0);
        check_val("instr_err", instr_err_o, p_vld && !p_own_data && p_err);
        check_val("data_rvalid", data_rvalid_o, p_vld && p_own_data);
        check_val("data_rdata", data_rdata_o, (p_vld && p_own_data && !p_err) ? p_dat : 32'h0);
        check_val("data_err", data_err_o, p_vld && p_own_data && p_err);
        p_vld = eg_i || eg_d;
        p_own_data = eg_d;
        p_err = err;
        p_dat = mem[idx];
        if (acc) m_last_a = idx;
        if (eg_i) m_last_data = 1'b0;
        else if (eg_d) m_last_data = 1'b1;
        g_i = eg_i; g_d = eg_d;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_gnt"}, {instr_gnt_o, data_gnt_o}, 0);
        check_val({pfx, "_rvalid"}, {instr_rvalid_o, data_rvalid_o}, 0);
        check_val({pfx, "_err"}, {instr_err_o, data_err_o}, 0);
        check_val({pfx, "_rdata_or"}, instr_rdata_o | data_rdata_o, 0);
        check_val({pfx, "_csn"}, rom_csn_o, 1);
        check_val({pfx, "_a"}, rom_a_o, 0);
    endtask

    logic        ri, rd;
    logic [31:0] rai, rda;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0013;
        mem[31] = 32'h0100_006F;
        mem[36] = 32'h0000_0093;
        model_reset();

        #2;
        check_reset_outputs("por");
        @(posedge CLK); #1 RSTN = 1'b1;

        // Simultaneous first request: instr wins, data held and served next
        cyc(1'b1, 32'h0, 1'b1, 32'h90);
        cyc(1'b0, 32'h0, 1'b1, 32'h90);
        check_val("tp_instr_rdata_13", instr_rdata_o, 32'h0000_0013);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        check_val("tp_data_rdata_93", data_rdata_o, 32'h0000_0093);

        // Instr-only read of word 31
        cyc(1'b1, 32'h7C, 1'b0, 32'h0);
        check_val("tp_rom_a_31", rom_a_o, 31);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        check_val("tp_instr_rdata_6f", instr_rdata_o, 32'h0100_006F);

        // Continuous contention: alternation
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i * 4), 1'b1, 32'(64 + i * 4));

        // Idle: csn high, address held
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);

        // Index 800 on the data port
        cyc(1'b0, 32'h0, 1'b1, 32'hC80);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset in the cycle after a grant
        cyc(1'b1, 32'h10, 1'b0, 32'h0);
        @(posedge CLK); #1;
        instr_req_i = 1'b1; data_req_i = 1'b1;
        #2 RSTN = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge CLK); #1;
        instr_req_i = 1'b0; data_req_i = 1'b0;
        RSTN = 1'b1;
        model_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h4, 1'b1, 32'h8);
        check_val("rst_first_conflict", instr_gnt_o, 1);

        // Randomized traffic; ungranted requests hold req and addr
        ri = 1'b0; rd = 1'b0; rai = '0; rda = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(ri && !g_i)) begin
                ri  = ($urandom_range(0, 2) != 0);
                rai = $urandom;
                if ($urandom_range(0, 7) != 0) rai[1:0] = 2'b00;
            end
            if (!(rd && !g_d)) begin
                rd  = ($urandom_range(0, 2) != 0);
                rda = $urandom;
                if ($urandom_range(0, 7) != 0) rda[1:0] = 2'b00;
            end
            cyc(ri, rai, rd, rda);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
